aes_sbox_arbiter: RTL

Time-shared controller for a single 4-byte-wide S-box lookup port. The lookup port is an external combinational `S_Box` ROM read, 4 lanes per cycle. Two requesters share it: the cipher round datapath (SubBytes on a full 16-byte state) and the key expansion unit (SubWord on one 32-bit word). The block arbitrates between them and sequences a state over 4 beats. It registers the results and returns each with a one-cycle done pulse, so one ROM replaces the 16-lane SubBytes array plus the key-schedule S-box.

---
 rtl/aes_sbox_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/aes_sbox_arbiter.sv
// Shares one 4-lane S-box ROM port between the round SubBytes and key SubWord requesters.
// Build option AES_SBOX_ARB_KEY_PRIORITY_EN: key wins every tie instead of round-robin.
//
//   state | meaning
//   IDLE  | arbitrate, capture the granted request
//   RND   | one beat per column, Nb beats
//   KEY   | single beat for the key word
//   DONE  | done pulse to the granted requester
module aes_sbox_arbiter #(
    parameter int NB = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rnd_valid,
    output logic              rnd_ready,
    input  logic [32*NB-1:0]  rnd_state_in,
    output logic              rnd_done,
    output logic [32*NB-1:0]  rnd_state_out,
    input  logic              key_valid,
    output logic              key_ready,
    input  logic [31:0]       key_word_in,
    output logic              key_done,
    output logic [31:0]       key_word_out,
    output logic [31:0]       sbox_addr,
    input  logic [31:0]       sbox_data
);

    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {IDLE, RND, KEY, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [BW-1:0]     beat;
    logic [32*NB-1:0]  cap;
    logic              cur_key;
    logic              grant_rnd;
    logic              grant_key;
    logic              tie_to_rnd;
    logic              last_beat;
    logic [31:0]       beat_word;

`ifdef AES_SBOX_ARB_KEY_PRIORITY_EN
    assign tie_to_rnd = 1'b0;
`else
    logic last_grant_key;
    // The round requester wins a tie only if the key requester was served last.
    assign tie_to_rnd = last_grant_key;
`endif

    assign last_beat = (int'(beat) == NB - 1);

    always_comb begin
        beat_word = '0;
        for (int i = 0; i < NB; i++) begin
            if (int'(beat) == i) beat_word = cap[32*i +: 32];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_rnd)      state_nxt = RND;
                else if (grant_key) state_nxt = KEY;
            end
            RND:     if (last_beat) state_nxt = DONE;
            KEY:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant_rnd = 1'b0;
        grant_key = 1'b0;
        if (state == IDLE && !reset) begin
            if (rnd_valid && (!key_valid || tie_to_rnd)) grant_rnd = 1'b1;
            else if (key_valid)                          grant_key = 1'b1;
        end
        rnd_ready = grant_rnd;
        key_ready = grant_key;
        // Gating with reset suppresses the pulse when DONE is aborted.
        rnd_done  = (state == DONE) && !cur_key && !reset;
        key_done  = (state == DONE) &&  cur_key && !reset;
        case (state)
            RND:     sbox_addr = beat_word;
            KEY:     sbox_addr = cap[31:0];
            default: sbox_addr = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            beat          <= '0;
            cap           <= '0;
            cur_key       <= 1'b0;
            rnd_state_out <= '0;
            key_word_out  <= '0;
`ifndef AES_SBOX_ARB_KEY_PRIORITY_EN
            last_grant_key <= 1'b1;
`endif
        end else begin
            if (grant_rnd) begin
                cap     <= rnd_state_in;
                cur_key <= 1'b0;
                beat    <= '0;
            end
            if (grant_key) begin
                cap[31:0] <= key_word_in;
                cur_key   <= 1'b1;
            end
            if (state == RND) begin
                for (int i = 0; i < NB; i++) begin
                    if (int'(beat) == i) rnd_state_out[32*i +: 32] <= sbox_data;
                end
                beat <= last_beat ? '0 : beat + BW'(1);
            end
            if (state == KEY) key_word_out <= sbox_data;
`ifndef AES_SBOX_ARB_KEY_PRIORITY_EN
            if (state == DONE) last_grant_key <= cur_key;
`endif
        end
    end

endmodule
